// File: rtl/keypad_scanner_pkg.sv
// keypad_pkg: shared types and helpers for the matrix keypad scanner.
//   kp_state_t    - debounce FSM state encoding (also exported for debug)
//   frame_class_t - classification of one full column scan
//   HEX_TABLE     - calculator legend of the 4x4 keypad, row-major
//   map_key()     - converts a row*NUM_COLS+col index into the emitted code
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_PRESS_DB   = 2'd1,
      ST_HELD       = 2'd2,
      ST_RELEASE_DB = 2'd3
   } kp_state_t;

   typedef enum logic [1:0] {
      FC_NONE   = 2'd0,
      FC_SINGLE = 2'd1,
      FC_MULTI  = 2'd2
   } frame_class_t;

   // Row-major legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
   localparam logic [3:0] HEX_TABLE [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   // hex_map == 1 selects the calculator legend (only meaningful for a 4x4
   // matrix); any other value passes the raw index through.
   function automatic logic [7:0] map_key(input logic [7:0] index, input int hex_map);
      if (hex_map == 1) map_key = {4'h0, HEX_TABLE[index[3:0]]};
      else              map_key = index;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: pin-side and event-side signals of the keypad scanner.
//   rows           - keypad rows, active-low, asynchronous to clk
//   columns        - one-hot active-low column drive
//   keycode_output - code of the last accepted key
//   key_valid      - one-cycle strobe on an accepted press
//   key_held       - level, high from accepted press to accepted release
//   key_release    - one-cycle strobe on an accepted release
//   state_dbg      - current debounce FSM state, for observation only
// Modports: master = the scanner, slave = keypad pins plus event consumer.
interface keypad_scanner_if #(
   parameter int NUM_ROWS = 4,
   parameter int NUM_COLS = 4,
   parameter int KW       = 4
);
   import keypad_pkg::*;

   logic [NUM_ROWS-1:0] rows;
   logic [NUM_COLS-1:0] columns;
   logic [KW-1:0]       keycode_output;
   // Event semantics: key_valid and key_release are fire-and-forget strobes
   // with no ready/backpressure. keycode_output is already stable in the
   // cycle key_valid is high and stays stable until the next accepted press;
   // a consumer must sample it on the strobe cycle or any time afterwards.
   logic                key_valid;
   logic                key_held;
   logic                key_release;
   kp_state_t           state_dbg;

   modport master (
      input  rows,
      output columns, keycode_output, key_valid, key_held, key_release, state_dbg
   );

   modport slave (
      output rows,
      input  columns, keycode_output, key_valid, key_held, key_release, state_dbg
   );
endinterface

// File: rtl/keypad_scanner_col_scanner.sv
// keypad_col_scanner: drives the columns, synchronises the rows and
// classifies each full scan frame.
//   clk, reset  - system clock, synchronous active-high reset
//   rows        - raw keypad rows (active-low, asynchronous)
//   columns     - registered one-hot active-low column drive
//   frame_done  - high on the last clock of a frame (last sample cycle)
//   frame_class - NONE / SINGLE / MULTI for the frame ending this cycle
//   key_index   - row*NUM_COLS+col of the pressed key when SINGLE
module keypad_col_scanner
   import keypad_pkg::*;
#(
   parameter int NUM_ROWS = 4,
   parameter int NUM_COLS = 4,
   parameter int SCAN_DIV = 1000,
   parameter int IW       = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_ROWS-1:0] rows,
   output logic [NUM_COLS-1:0] columns,
   output logic                frame_done,
   output frame_class_t        frame_class,
   output logic [IW-1:0]       key_index
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(NUM_COLS);

   logic [NUM_ROWS-1:0] rows_meta;
   logic [NUM_ROWS-1:0] rows_sync;
   logic [DW-1:0]       dwell;
   logic [CW-1:0]       col_idx;
   logic [CW-1:0]       col_next;
   logic [NUM_COLS-1:0] drive_next;
   logic                dwell_last;
   logic                col_last;

   // Running tally of intersections seen so far in this frame, saturating
   // at 2 because only "none / one / more" matters.
   logic [1:0]          hit_cnt;
   logic [IW-1:0]       hit_idx;

   logic [1:0]          col_hits;
   int                  row_sel;
   logic [IW-1:0]       this_idx;
   logic [2:0]          hit_sum;
   logic [1:0]          hit_total;
   logic [IW-1:0]       merged_idx;

   always_comb begin
      dwell_last = (dwell == DW'(SCAN_DIV - 1));
      col_last   = (col_idx == CW'(NUM_COLS - 1));
      col_next   = col_idx;
      if (dwell_last) col_next = col_last ? '0 : col_idx + CW'(1);
      // The column register is loaded with the drive for the index that
      // will be current next cycle, so drive and col_idx stay aligned.
      drive_next = '1;
      for (int c = 0; c < NUM_COLS; c++) begin
         drive_next[c] = (col_next != CW'(c));
      end
   end

   // Classification of the currently sampled column merged with the tally.
   always_comb begin
      col_hits = 2'd0;
      row_sel  = 0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (!rows_sync[r]) begin
            if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
            row_sel = r;
         end
      end
      this_idx   = IW'(row_sel * NUM_COLS + int'(col_idx));
      hit_sum    = {1'b0, hit_cnt} + {1'b0, col_hits};
      hit_total  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      merged_idx = (col_hits != 2'd0) ? this_idx : hit_idx;

      frame_done = dwell_last && col_last;
      key_index  = merged_idx;
      case (hit_total)
         2'd0:    frame_class = FC_NONE;
         2'd1:    frame_class = FC_SINGLE;
         default: frame_class = FC_MULTI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rows_meta <= '1;
         rows_sync <= '1;
         dwell     <= '0;
         col_idx   <= '0;
         columns   <= '1;
         hit_cnt   <= 2'd0;
         hit_idx   <= '0;
      end else begin
         rows_meta <= rows;
         rows_sync <= rows_meta;
         dwell     <= dwell_last ? '0 : dwell + DW'(1);
         col_idx   <= col_next;
         columns   <= drive_next;
         // Sample on the last clock of the dwell: SCAN_DIV-3 settle clocks
         // remain after the two synchroniser stages.
         if (dwell_last) begin
            if (col_last) begin
               hit_cnt <= 2'd0;
               hit_idx <= '0;
            end else begin
               hit_cnt <= hit_total;
               hit_idx <= merged_idx;
            end
         end
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: R x C matrix keypad scanner with frame-based debounce.
//   clk, reset - system clock, synchronous active-high reset
//   bus        - keypad_scanner_if master: rows in, columns out, keycode,
//                press/release strobes, held level and FSM debug state
// The column scanner delivers one classified frame per NUM_COLS dwells;
// this level runs the press/release debounce FSM and owns the outputs.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int NUM_ROWS        = 4,
   parameter int NUM_COLS        = 4,
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_FRAMES = 4,
   parameter int HEX_MAP         = 1
) (
   input  logic              clk,
   input  logic              reset,
   keypad_scanner_if.master  bus
);

   localparam int IW  = $clog2(NUM_ROWS * NUM_COLS);
   localparam int KW  = (IW > 4) ? IW : 4;
   localparam int DBW = $clog2(DEBOUNCE_FRAMES + 1);
   // The calculator legend only exists for a 4x4 matrix; other shapes
   // always emit the raw index.
   localparam int MAP_MODE = (HEX_MAP == 1 && NUM_ROWS == 4 && NUM_COLS == 4) ? 1 : 0;

   localparam logic [1:0] S_IDLE       = ST_IDLE;
   localparam logic [1:0] S_PRESS_DB   = ST_PRESS_DB;
   localparam logic [1:0] S_HELD       = ST_HELD;
   localparam logic [1:0] S_RELEASE_DB = ST_RELEASE_DB;

   localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_FRAMES);

   logic               frame_done;
   frame_class_t       frame_class;
   logic [IW-1:0]      key_index;

   logic [1:0]         state;
   logic [IW-1:0]      cand;
   logic [DBW-1:0]     cnt;
   logic [DBW-1:0]     cnt_inc;
   logic               cnt_full;
   logic               is_single;
   logic               is_none;

   logic [KW-1:0]      keycode_q;
   logic               key_valid_q;
   logic               key_held_q;
   logic               key_release_q;

   keypad_col_scanner #(
      .NUM_ROWS (NUM_ROWS),
      .NUM_COLS (NUM_COLS),
      .SCAN_DIV (SCAN_DIV),
      .IW       (IW)
   ) u_col_scanner (
      .clk         (clk),
      .reset       (reset),
      .rows        (bus.rows),
      .columns     (bus.columns),
      .frame_done  (frame_done),
      .frame_class (frame_class),
      .key_index   (key_index)
   );

   always_comb begin
      cnt_inc   = cnt + DBW'(1);
      cnt_full  = (cnt_inc == DB_MAX);
      is_single = (frame_class == FC_SINGLE);
      is_none   = (frame_class == FC_NONE);
   end

   // The counter is cleared on every exit from a debounce state, so it
   // never exceeds DEBOUNCE_FRAMES and never wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         cand          <= '0;
         cnt           <= '0;
         keycode_q     <= '0;
         key_valid_q   <= 1'b0;
         key_held_q    <= 1'b0;
         key_release_q <= 1'b0;
      end else begin
         key_valid_q   <= 1'b0;
         key_release_q <= 1'b0;
         if (frame_done) begin
            case (state)
               S_IDLE: begin
                  if (is_single) begin
                     cand <= key_index;
                     if (DEBOUNCE_FRAMES == 1) begin
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        keycode_q   <= KW'(map_key(8'(key_index), MAP_MODE));
                        cnt         <= '0;
                        state       <= S_HELD;
                     end else begin
                        cnt   <= DBW'(1);
                        state <= S_PRESS_DB;
                     end
                  end
               end
               S_PRESS_DB: begin
                  if (is_single) begin
                     if (key_index == cand) begin
                        if (cnt_full) begin
                           key_valid_q <= 1'b1;
                           key_held_q  <= 1'b1;
                           keycode_q   <= KW'(map_key(8'(key_index), MAP_MODE));
                           cnt         <= '0;
                           state       <= S_HELD;
                        end else begin
                           cnt <= cnt_inc;
                        end
                     end else begin
                        // A different single key restarts the candidate.
                        cand <= key_index;
                        cnt  <= DBW'(1);
                     end
                  end else begin
                     cnt   <= '0;
                     state <= S_IDLE;
                  end
               end
               S_HELD: begin
                  // Extra keys while held are ignored; only an empty frame
                  // starts the release debounce.
                  if (is_none) begin
                     if (DEBOUNCE_FRAMES == 1) begin
                        key_release_q <= 1'b1;
                        key_held_q    <= 1'b0;
                        cnt           <= '0;
                        state         <= S_IDLE;
                     end else begin
                        cnt   <= DBW'(1);
                        state <= S_RELEASE_DB;
                     end
                  end
               end
               S_RELEASE_DB: begin
                  if (is_none) begin
                     if (cnt_full) begin
                        key_release_q <= 1'b1;
                        key_held_q    <= 1'b0;
                        cnt           <= '0;
                        state         <= S_IDLE;
                     end else begin
                        cnt <= cnt_inc;
                     end
                  end else begin
                     cnt   <= '0;
                     state <= S_HELD;
                  end
               end
               default: begin
                  cnt   <= '0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.keycode_output = keycode_q;
   assign bus.key_valid      = key_valid_q;
   assign bus.key_held       = key_held_q;
   assign bus.key_release    = key_release_q;
   assign bus.state_dbg      = kp_state_t'(state);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: 4x4, SCAN_DIV=4, DEBOUNCE_FRAMES=3, HEX_MAP=1.
// A 16-clock frame grid is counted from reset; key sets change only at
// frame starts. A frame-level model derives the expected events from the
// key set held through each frame; directed literals pin the model.
module tb_keypad_scanner;

   localparam int DB    = 3;
   localparam int FRAME = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   keypad_scanner_if #(.NUM_ROWS(4), .NUM_COLS(4), .KW(4)) bus ();

   keypad_scanner #(
      .NUM_ROWS        (4),
      .NUM_COLS        (4),
      .SCAN_DIV        (4),
      .DEBOUNCE_FRAMES (DB),
      .HEX_MAP         (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- keypad physics ----------------
   logic [15:0] pressed = '0;
   logic [3:0]  rows_v;

   always_comb begin
      rows_v = '1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !bus.columns[c]) rows_v[r] = 1'b0;
         end
      end
   end
   assign bus.rows = rows_v;

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic rst_at_edge = 1'b1;
   event frame_start;

   int valid_cnt        = 0;
   int release_cnt      = 0;
   int last_valid_cyc   = -1;
   int last_release_cyc = -1;

   // Model: run length of identical frames toward the next accept/release.
   logic        m_held  = 1'b0;
   logic [3:0]  m_code  = 4'h0;
   int          run_len = 0;
   int          run_key = 0;
   logic        exp_valid;
   logic        exp_release;
   logic [3:0]  exp_cols;
   logic [3:0]  one_col = 4'b0001;
   logic [63:0] hex_digits = 64'h123A_456B_789C_E0FD;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int first_key(input logic [15:0] s);
      int k;
      k = 0;
      for (int i = 15; i >= 0; i--) if (s[i]) k = i;
      return k;
   endfunction

   always @(posedge clk) rst_at_edge <= reset;

   always @(negedge clk) begin
      int nk;
      int k;
      exp_valid   = 1'b0;
      exp_release = 1'b0;
      if (rst_at_edge) begin
         cyc     = 0;
         m_held  = 1'b0;
         m_code  = 4'h0;
         run_len = 0;
         run_key = 0;
      end else begin
         cyc++;
         if (cyc % FRAME == 0) begin
            nk = $countones(pressed);
            k  = first_key(pressed);
            if (!m_held) begin
               if (nk == 1) begin
                  if (run_len > 0 && k == run_key) run_len++;
                  else begin
                     run_key = k;
                     run_len = 1;
                  end
               end else begin
                  run_len = 0;
               end
               if (run_len == DB) begin
                  m_held    = 1'b1;
                  m_code    = hex_digits[(15-k)*4 +: 4];
                  exp_valid = 1'b1;
                  run_len   = 0;
               end
            end else begin
               if (nk == 0) run_len++;
               else         run_len = 0;
               if (run_len == DB) begin
                  m_held      = 1'b0;
                  exp_release = 1'b1;
                  run_len     = 0;
               end
            end
         end
      end
      exp_cols = rst_at_edge ? 4'hF : ~(one_col << ((cyc / 4) % 4));
      check("columns", bus.columns, exp_cols);
      check("key_valid", bus.key_valid, exp_valid);
      check("key_release", bus.key_release, exp_release);
      check("key_held", bus.key_held, m_held);
      check("keycode", bus.keycode_output, m_code);
      if (bus.key_valid) begin
         valid_cnt++;
         last_valid_cyc = cyc;
      end
      if (bus.key_release) begin
         release_cnt++;
         last_release_cyc = cyc;
      end
      if (!rst_at_edge && (cyc % FRAME == 0)) -> frame_start;
   end

   // ---------------- driver ----------------
   task automatic frames(input logic [15:0] keys, input int n);
      pressed = keys;
      repeat (n) @(frame_start);
   endtask

   initial begin
      int t0;
      int v0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_columns", bus.columns, 4'hF);
      check("rst_keycode", bus.keycode_output, 4'h0);
      check("rst_events", {bus.key_valid, bus.key_held, bus.key_release}, 3'b000);
      reset = 1'b0;
      @(frame_start);

      // idle
      frames(16'h0000, 4);
      check("idle_valid_cnt", valid_cnt, 0);
      check("idle_release_cnt", release_cnt, 0);

      // key "6" (row1/col2)
      t0 = cyc;
      frames(16'h0040, 4);
      check("k6_valid_cnt", valid_cnt, 1);
      check("k6_valid_cyc", last_valid_cyc, t0 + 48);
      check("k6_code", bus.keycode_output, 4'h6);
      check("k6_held", bus.key_held, 1'b1);
      t0 = cyc;
      frames(16'h0000, 4);
      check("k6_release_cnt", release_cnt, 1);
      check("k6_release_cyc", last_release_cyc, t0 + 48);
      check("k6_code_kept", bus.keycode_output, 4'h6);
      check("k6_held_low", bus.key_held, 1'b0);

      // bounce on "5": 2 frames, gap, 3 frames
      t0 = cyc;
      frames(16'h0020, 2);
      frames(16'h0000, 1);
      frames(16'h0020, 3);
      check("b5_valid_cnt", valid_cnt, 2);
      check("b5_valid_cyc", last_valid_cyc, t0 + 96);
      check("b5_code", bus.keycode_output, 4'h5);
      frames(16'h0000, 4);
      check("b5_release_cnt", release_cnt, 2);

      // "1" and "9" together, then "9" released
      frames(16'h0401, 4);
      check("multi_no_valid", valid_cnt, 2);
      t0 = cyc;
      frames(16'h0001, 4);
      check("k1_valid_cnt", valid_cnt, 3);
      check("k1_valid_cyc", last_valid_cyc, t0 + 48);
      check("k1_code", bus.keycode_output, 4'h1);
      frames(16'h0000, 4);
      check("k1_release_cnt", release_cnt, 3);

      // "*" held, then "0" added, then both released
      frames(16'h1000, 4);
      check("kstar_valid_cnt", valid_cnt, 4);
      check("kstar_code", bus.keycode_output, 4'hE);
      frames(16'h3000, 4);
      check("kstar0_no_valid", valid_cnt, 4);
      check("kstar0_held", bus.key_held, 1'b1);
      check("kstar0_no_release", release_cnt, 3);
      t0 = cyc;
      frames(16'h0000, 4);
      check("kstar_release_cnt", release_cnt, 4);
      check("kstar_release_cyc", last_release_cyc, t0 + 48);
      check("kstar_code_kept", bus.keycode_output, 4'hE);

      // reset while debouncing "6" at count 2
      frames(16'h0040, 2);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("prst_columns", bus.columns, 4'hF);
      check("prst_no_valid", bus.key_valid, 1'b0);
      check("prst_keycode", bus.keycode_output, 4'h0);
      reset = 1'b0;
      v0 = valid_cnt;
      frames(16'h0040, 4);
      check("prst_valid_cnt", valid_cnt, v0 + 1);
      check("prst_valid_cyc", last_valid_cyc, 48);
      check("prst_code", bus.keycode_output, 4'h6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised successor to the 4x4 keypad decoder.
- Actively scans an R x C matrix keypad by driving columns and sampling rows.
- Synchronises and debounces the row inputs, rejects multi-key frames, and emits one-cycle press/release events with a hex keycode.
- Sits between the keypad pins and the calculator input FSM, replacing direct row/column decoding.

Parameters:
- NUM_ROWS, 4, number of row inputs (2..8)
- NUM_COLS, 4, number of column outputs (2..8)
- SCAN_DIV, 1000, clocks each column is driven per dwell (>=3)
- DEBOUNCE_FRAMES, 4, consecutive identical full-scan frames required to accept a press or release (>=1)
- HEX_MAP, 1, 1 = 4x4 calculator map (1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D); 0 = raw index row*NUM_COLS+col; HEX_MAP=1 legal only for 4x4

Ports:
- clk, input, 1, system clock
- reset, input, 1, synchronous active-high reset
- rows, input, NUM_ROWS, keypad rows, active-low (external pull-ups), asynchronous
- columns, output, NUM_COLS, column drive, one-hot active-low (driven column 0, all others 1)
- keycode_output, output, KW=max(4,clog2(NUM_ROWS*NUM_COLS)), code of the last accepted key
- key_valid, output, 1, one-cycle pulse on accepted press
- key_held, output, 1, high from accepted press until accepted release
- key_release, output, 1, one-cycle pulse on accepted release

Behaviour:
- Reset values: columns all 1; keycode_output 0; key_valid, key_held, key_release 0. Internally: column index 0, dwell and debounce counters 0, state IDLE, synchroniser flops all 1.
- Reset is synchronous and overrides everything, including mid-frame or mid-debounce. No event pulse is emitted on reset.
- rows pass through a 2-flop synchroniser before any use.
- Column drive: column index c drives bit c low for SCAN_DIV clocks, then c increments, wrapping NUM_COLS-1 -> 0.
- Sampling: on the last clock of each dwell, the synchronised rows for column c are captured. This gives SCAN_DIV-3 settle clocks after synchroniser latency.
- Frame: NUM_COLS dwells. At each frame end, the frame is classified:
  - NONE: no row low in any column.
  - SINGLE(k): exactly one row/column intersection low.
  - MULTI: two or more intersections low.
- FSM states IDLE, PRESS_DB, HELD, RELEASE_DB:
  - IDLE: SINGLE(k) -> latch candidate k, count=1. If DEBOUNCE_FRAMES==1, go directly to the accept action; otherwise go to PRESS_DB. NONE or MULTI -> stay.
  - PRESS_DB: SINGLE(k) with the same k -> count+1. When count reaches DEBOUNCE_FRAMES, accept: key_valid=1 for one clock, keycode_output=map(k), key_held=1, go to HELD. SINGLE(other) -> restart with the new candidate, count=1. NONE or MULTI -> IDLE.
  - HELD: NONE -> count=1, go to RELEASE_DB (or release immediately if DEBOUNCE_FRAMES==1). SINGLE(any) or MULTI -> stay. A second key while held never produces a new event.
  - RELEASE_DB: NONE -> count+1. At DEBOUNCE_FRAMES, release: key_release=1 for one clock, key_held=0, go to IDLE. SINGLE or MULTI -> back to HELD.
- keycode_output holds its value after release until the next accepted press.
- Latency: a key stable from the start of frame F gives key_valid on the clock after the end of frame F+DEBOUNCE_FRAMES-1.
- key_valid and key_release are never high in the same cycle.
- Counter widths: dwell counter clog2(SCAN_DIV); debounce counter clog2(DEBOUNCE_FRAMES+1). Neither counter ever wraps past its terminal value.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (IDLE, PRESS_DB, HELD, RELEASE_DB);
  - the frame-class enum (NONE, SINGLE, MULTI);
  - the 16-entry 4x4 hex map constant;
  - a function map_key(index, HEX_MAP).
- One sub-module, keypad_col_scanner: synchroniser, dwell counter, column drive, and per-frame classification. It outputs frame_done, frame_class and key_index.
- The top level holds the debounce FSM and the output registers.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, 4x4, HEX_MAP=1; frame = 16 clk):
- Reset then idle rows=4'hF -> columns cycle 1110,1101,1011,0111 every 4 clk; no events; all outputs 0.
- Hold row1/col2 (the "6" key) stable -> key_valid single pulse exactly 1 clk after the 3rd frame end, keycode_output=4'h6, key_held=1. Release -> key_release pulse 3 frames later; keycode_output stays 6.
- Bounce: "5" pressed 2 frames, NONE 1 frame, then pressed 3 frames -> exactly one key_valid, at the end of the second run.
- Two keys ("1" and "9") pressed together from IDLE -> no event. Release "9" -> "1" accepted after 3 frames with code 4'h1.
- While "*" is held (code 4'hE), additionally press "0" -> no new key_valid. Release both -> one key_release.
- Assert reset in PRESS_DB at count=2 -> columns=all 1 next clk, no pulse. Key still held after reset -> key_valid after 3 full frames.
